step_enable_gen: RTL

Receive-side companion to the CPU slow-clock toggle generator. Takes an asynchronous toggling level (divided clock or manual step button) into the 50 MHz `clk_signal` domain. Synchronizes and debounces it, detects the selected edge(s), and emits a single-cycle `step_en` clock-enable for the RV32 pipeline. This replaces driving pipeline registers from a fabric-generated clock.

---
 rtl/step_enable_gen.sv | 135 +++++++++++++
 1 files changed

// File: rtl/step_enable_gen.sv
// Synchronizes, debounces and edge-detects an asynchronous toggling level into a
// one-cycle step_en clock-enable. Optional step counter enabled by STEP_COUNTER_EN.
module step_enable_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        clk_signal,
    input  logic        reset,
    input  logic        toggle_in,
    input  logic [1:0]  edge_sel,
    input  logic        halt,
    output logic        step_en,
    output logic        level_out,
    output logic [31:0] step_count
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        QUAL_HIGH,
        STABLE_HIGH,
        QUAL_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_lvl;
    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   rise_ok;
    logic                   fall_ok;
    logic                   commit_rise;
    logic                   commit_fall;
    logic                   pulse_next;

    always_ff @(posedge clk_signal or posedge reset) begin
        if (reset) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= toggle_in;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk_signal or posedge reset) begin
                if (reset) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sync_lvl = sync_reg[SYNC_STAGES-1];

    // edge_sel and halt only matter in the commit cycle itself
    assign rise_ok     = (edge_sel == 2'b00) || (edge_sel == 2'b10);
    assign fall_ok     = (edge_sel == 2'b01) || (edge_sel == 2'b10);
    assign commit_rise = (state_reg == QUAL_HIGH) && sync_lvl  && (cnt_reg == CNT_MAX);
    assign commit_fall = (state_reg == QUAL_LOW)  && !sync_lvl && (cnt_reg == CNT_MAX);
    assign pulse_next  = ((commit_rise && rise_ok) || (commit_fall && fall_ok)) && !halt;

    always_ff @(posedge clk_signal or posedge reset) begin
        if (reset) begin
            state_reg <= STABLE_LOW;
            cnt_reg   <= '0;
            level_out <= 1'b0;
            step_en   <= 1'b0;
        end else begin
            step_en <= pulse_next;
            case (state_reg)
                STABLE_LOW: begin
                    if (sync_lvl) begin
                        state_reg <= QUAL_HIGH;
                        cnt_reg   <= '0;
                    end
                end
                QUAL_HIGH: begin
                    if (!sync_lvl) begin
                        state_reg <= STABLE_LOW;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        state_reg <= STABLE_HIGH;
                        level_out <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync_lvl) begin
                        state_reg <= QUAL_LOW;
                        cnt_reg   <= '0;
                    end
                end
                QUAL_LOW: begin
                    if (sync_lvl) begin
                        state_reg <= STABLE_HIGH;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        state_reg <= STABLE_LOW;
                        level_out <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= STABLE_LOW;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

`ifdef STEP_COUNTER_EN
    logic [31:0] step_count_reg;

    // Advances on the same edge that raises step_en; wraps naturally at 2^32
    always_ff @(posedge clk_signal or posedge reset) begin
        if (reset) begin
            step_count_reg <= '0;
        end else if (pulse_next) begin
            step_count_reg <= step_count_reg + 32'd1;
        end
    end

    assign step_count = step_count_reg;
`else
    assign step_count = 32'd0;
`endif

endmodule
